// File: rtl/reversi_control.sv
// reversi_control
// Game-flow controller for the Reversi datapath. It sequences the board draw,
// cursor handling, move check, placement, flipping, scoring and turn
// bookkeeping. Each work state raises a single operation enable and waits for
// the datapath's go strobe. A wait counter aborts a stalled operation and sets
// a sticky timeoutErr.
//
// Ports
//   clk, resetn                      clock; synchronous active-low reset
//   enterKey/rightKey/leftKey/
//   upKey/downKey                    single-cycle key pulses
//   go                               done strobe for the enabled operation
//   validMove                        check result, qualified by go in CHECK
//   hasTurn                          has-turn result, qualified by go in HAS_OPP/HAS_CUR
//   *En                              registered operation enables / cursor pulses
//   determineOpponent/Current        qualifiers for determineHasTurnEn
//   gameOver                         high while in GAME_OVER
//   timeoutErr                       sticky abort flag
//   state_dbg                        current state encoding
module reversi_control #(
    parameter int GO_TIMEOUT = 2000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enterKey,
    input  logic       rightKey,
    input  logic       leftKey,
    input  logic       upKey,
    input  logic       downKey,
    input  logic       go,
    input  logic       validMove,
    input  logic       hasTurn,
    output logic       writeEn,
    output logic       drawBoardEn,
    output logic       drawInitialPiecesEn,
    output logic       moveHighlightEn,
    output logic       checkIfValidMoveEn,
    output logic       placeEn,
    output logic       flipEn,
    output logic       scoreManagerEn,
    output logic       determineHasTurnEn,
    output logic       TurnManagerEn,
    output logic       removeHighlightEn,
    output logic       moveRightEn,
    output logic       moveLeftEn,
    output logic       moveUpEn,
    output logic       moveDownEn,
    output logic       determineOpponent,
    output logic       determineCurrent,
    output logic       gameOver,
    output logic       timeoutErr,
    output logic [3:0] state_dbg
);

    localparam int CNT_NEED = $clog2(GO_TIMEOUT + 1);
    localparam int CNT_W    = (CNT_NEED > 21) ? CNT_NEED : 21;

    typedef enum logic [3:0] {
        DRAW_BOARD = 4'd0,  DRAW_INIT = 4'd1,  HIGHLIGHT  = 4'd2,
        WAIT_INPUT = 4'd3,  MOVE      = 4'd4,  CHECK      = 4'd5,
        PLACE      = 4'd6,  FLIP      = 4'd7,  SCORE      = 4'd8,
        HAS_OPP    = 4'd9,  HAS_CUR   = 4'd10, TURN       = 4'd11,
        REMOVE_HL  = 4'd12, GAME_OVER = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0, DIR_LEFT = 2'd1, DIR_UP = 2'd2, DIR_DOWN = 2'd3
    } dir_t;

    typedef struct packed {
        logic write_en;
        logic draw_board_en;
        logic draw_init_en;
        logic highlight_en;
        logic check_en;
        logic place_en;
        logic flip_en;
        logic score_en;
        logic has_turn_en;
        logic turn_en;
        logic remove_hl_en;
        logic move_right;
        logic move_left;
        logic move_up;
        logic move_down;
        logic det_opponent;
        logic det_current;
        logic game_over;
    } ctrl_t;

    state_t             state_q, state_d;
    dir_t               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_err_q, timeout_err_d;
    ctrl_t              ctrl_q, ctrl_d;

    logic               work;
    logic               leave;
    state_t             go_next;

    // State register; outputs are registered from the decoded next state so
    // they line up with state_q in every cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= DRAW_BOARD;
            dir_q         <= DIR_RIGHT;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            ctrl_q        <= '0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            ctrl_q        <= ctrl_d;
        end
    end

    // Next-state logic. go takes priority over a timeout in the same cycle.
    // A timeout may re-enter DRAW_BOARD from itself, so the counter is cleared
    // on any taken transition rather than only on a change of state code.
    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        timeout_err_d = timeout_err_q;
        work          = 1'b1;
        leave         = 1'b0;
        go_next       = state_q;

        case (state_q)
            DRAW_BOARD: go_next = DRAW_INIT;
            DRAW_INIT:  go_next = HIGHLIGHT;
            HIGHLIGHT:  go_next = WAIT_INPUT;
            CHECK:      go_next = validMove ? PLACE : WAIT_INPUT;
            PLACE:      go_next = FLIP;
            FLIP:       go_next = SCORE;
            SCORE:      go_next = HAS_OPP;
            HAS_OPP:    go_next = hasTurn ? TURN : HAS_CUR;
            HAS_CUR:    go_next = hasTurn ? HIGHLIGHT : REMOVE_HL;
            TURN:       go_next = HIGHLIGHT;
            REMOVE_HL:  go_next = GAME_OVER;
            default:    work    = 1'b0;
        endcase

        if (work) begin
            if (go) begin
                state_d = go_next;
                leave   = 1'b1;
            end else if (cnt_q == CNT_W'(GO_TIMEOUT - 1)) begin
                timeout_err_d = 1'b1;
                leave         = 1'b1;
                if (state_q == DRAW_BOARD || state_q == DRAW_INIT || state_q == HIGHLIGHT)
                    state_d = DRAW_BOARD;
                else
                    state_d = WAIT_INPUT;
            end
        end else begin
            case (state_q)
                WAIT_INPUT: begin
                    if (enterKey) begin
                        state_d = CHECK;
                    end else if (rightKey) begin
                        state_d = MOVE;
                        dir_d   = DIR_RIGHT;
                    end else if (leftKey) begin
                        state_d = MOVE;
                        dir_d   = DIR_LEFT;
                    end else if (upKey) begin
                        state_d = MOVE;
                        dir_d   = DIR_UP;
                    end else if (downKey) begin
                        state_d = MOVE;
                        dir_d   = DIR_DOWN;
                    end
                end
                MOVE:      state_d = HIGHLIGHT;
                GAME_OVER: state_d = GAME_OVER;
                default:   state_d = DRAW_BOARD;
            endcase
        end

        cnt_d = (work && !leave) ? cnt_q + 1'b1 : '0;
    end

    // Output decode of the state being entered.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            DRAW_BOARD: begin ctrl_d.draw_board_en = 1'b1; ctrl_d.write_en = 1'b1; end
            DRAW_INIT:  begin ctrl_d.draw_init_en  = 1'b1; ctrl_d.write_en = 1'b1; end
            HIGHLIGHT:  begin ctrl_d.highlight_en  = 1'b1; ctrl_d.write_en = 1'b1; end
            CHECK:      ctrl_d.check_en = 1'b1;
            PLACE:      begin ctrl_d.place_en      = 1'b1; ctrl_d.write_en = 1'b1; end
            FLIP:       begin ctrl_d.flip_en       = 1'b1; ctrl_d.write_en = 1'b1; end
            SCORE:      ctrl_d.score_en = 1'b1;
            HAS_OPP:    begin ctrl_d.has_turn_en = 1'b1; ctrl_d.det_opponent = 1'b1; end
            HAS_CUR:    begin ctrl_d.has_turn_en = 1'b1; ctrl_d.det_current  = 1'b1; end
            TURN:       ctrl_d.turn_en = 1'b1;
            REMOVE_HL:  begin ctrl_d.remove_hl_en  = 1'b1; ctrl_d.write_en = 1'b1; end
            GAME_OVER:  ctrl_d.game_over = 1'b1;
            MOVE: begin
                case (dir_d)
                    DIR_RIGHT: ctrl_d.move_right = 1'b1;
                    DIR_LEFT:  ctrl_d.move_left  = 1'b1;
                    DIR_UP:    ctrl_d.move_up    = 1'b1;
                    default:   ctrl_d.move_down  = 1'b1;
                endcase
            end
            default: ctrl_d = '0;
        endcase
    end

    assign writeEn             = ctrl_q.write_en;
    assign drawBoardEn         = ctrl_q.draw_board_en;
    assign drawInitialPiecesEn = ctrl_q.draw_init_en;
    assign moveHighlightEn     = ctrl_q.highlight_en;
    assign checkIfValidMoveEn  = ctrl_q.check_en;
    assign placeEn             = ctrl_q.place_en;
    assign flipEn              = ctrl_q.flip_en;
    assign scoreManagerEn      = ctrl_q.score_en;
    assign determineHasTurnEn  = ctrl_q.has_turn_en;
    assign TurnManagerEn       = ctrl_q.turn_en;
    assign removeHighlightEn   = ctrl_q.remove_hl_en;
    assign moveRightEn         = ctrl_q.move_right;
    assign moveLeftEn          = ctrl_q.move_left;
    assign moveUpEn            = ctrl_q.move_up;
    assign moveDownEn          = ctrl_q.move_down;
    assign determineOpponent   = ctrl_q.det_opponent;
    assign determineCurrent    = ctrl_q.det_current;
    assign gameOver            = ctrl_q.game_over;
    assign timeoutErr          = timeout_err_q;
    assign state_dbg           = state_q;

endmodule
